// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: sequencer state encoding,
// opcode map and default datapath widths.
package cpu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int OPC_W_DEF  = 4;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC1 = 3'd2,
        ST_EXEC2 = 3'd3,
        ST_HALT  = 3'd4
    } seq_state_t;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JMI = 4'd5;
    localparam logic [3:0] OP_JEQ = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;
    localparam logic [3:0] OP_LDI = 4'd8;
    localparam logic [3:0] OP_LSR = 4'd10;
    localparam logic [3:0] OP_ASR = 4'd11;

endpackage

// File: rtl/instr_reg.sv
// Instruction register: splits a program word into opcode and operand and
// holds both until the next load.
module instr_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OPC_W  = OPC_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [DATA_W-1:0]       word,
    output logic [OPC_W-1:0]        opcode,
    output logic [DATA_W-OPC_W-1:0] operand
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcode  <= '0;
            operand <= '0;
        end else if (load) begin
            opcode  <= word[DATA_W-1 -: OPC_W];
            operand <= word[DATA_W-OPC_W-1:0];
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// FETCH/EXEC1/EXEC2 control sequencer with run/step/halt control, the
// instruction register, condition flags and a retired-instruction counter.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OPC_W  = OPC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    run,
    input  logic                    step,
    input  logic [DATA_W-1:0]       mem_q,
    input  logic [DATA_W-1:0]       acc,
    input  logic                    EXTRA,
    output logic                    FETCH,
    output logic                    EXEC1,
    output logic                    EXEC2,
    output logic [OPC_W-1:0]        IR,
    output logic [DATA_W-OPC_W-1:0] operand,
    output logic                    EQ,
    output logic                    MI,
    output logic                    halted,
    output logic [CNT_W-1:0]        instr_count
);

    seq_state_t state;
    seq_state_t state_nxt;
    seq_state_t after_retire;
    logic       step_pending;
    logic       pending_nxt;
    logic       retire;

    instr_reg #(
        .DATA_W (DATA_W),
        .OPC_W  (OPC_W)
    ) u_instr_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (state == ST_FETCH),
        .word    (mem_q),
        .opcode  (IR),
        .operand (operand)
    );

    // A pending single step forces a return to IDLE even if run is now high.
    always_comb begin
        state_nxt    = state;
        pending_nxt  = step_pending;
        retire       = 1'b0;
        after_retire = (run && !step_pending) ? ST_FETCH : ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nxt = ST_FETCH;
                end else if (step) begin
                    state_nxt   = ST_FETCH;
                    pending_nxt = 1'b1;
                end
            end
            ST_FETCH: state_nxt = ST_EXEC1;
            ST_EXEC1: begin
                if (IR == OPC_W'(OP_STP)) begin
                    state_nxt   = ST_HALT;
                    retire      = 1'b1;
                    pending_nxt = 1'b0;
                end else if (EXTRA) begin
                    state_nxt = ST_EXEC2;
                end else begin
                    state_nxt   = after_retire;
                    retire      = 1'b1;
                    pending_nxt = 1'b0;
                end
            end
            ST_EXEC2: begin
                state_nxt   = after_retire;
                retire      = 1'b1;
                pending_nxt = 1'b0;
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they line up with state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            step_pending <= 1'b0;
            FETCH        <= 1'b0;
            EXEC1        <= 1'b0;
            EXEC2        <= 1'b0;
            halted       <= 1'b0;
            instr_count  <= '0;
        end else begin
            state        <= state_nxt;
            step_pending <= pending_nxt;
            FETCH        <= (state_nxt == ST_FETCH);
            EXEC1        <= (state_nxt == ST_EXEC1);
            EXEC2        <= (state_nxt == ST_EXEC2);
            halted       <= (state_nxt == ST_HALT);
            if (retire) begin
                instr_count <= instr_count + 1'b1;
            end
        end
    end

    assign EQ = (acc == '0);
    assign MI = acc[DATA_W-1];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle expected strobes and counts
// are queued before each clock and compared after it.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run, step, EXTRA;
    logic [15:0] mem_q, acc;
    logic        FETCH, EXEC1, EXEC2, EQ, MI, halted;
    logic [3:0]  IR;
    logic [11:0] operand;
    logic [15:0] instr_count;

    // Narrow-counter instance used to exercise counter wrap in few cycles.
    logic        run_s;
    logic        FETCH_s, EXEC1_s, EXEC2_s, EQ_s, MI_s, halted_s;
    logic [3:0]  IR_s;
    logic [11:0] operand_s;
    logic [3:0]  instr_count_s;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic        f;
        logic        e1;
        logic        e2;
        logic        h;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    cpu_sequencer #(.DATA_W(16), .OPC_W(4), .CNT_W(16)) dut (
        .clk (clk), .reset_n (reset_n), .run (run), .step (step),
        .mem_q (mem_q), .acc (acc), .EXTRA (EXTRA),
        .FETCH (FETCH), .EXEC1 (EXEC1), .EXEC2 (EXEC2),
        .IR (IR), .operand (operand), .EQ (EQ), .MI (MI),
        .halted (halted), .instr_count (instr_count)
    );

    cpu_sequencer #(.DATA_W(16), .OPC_W(4), .CNT_W(4)) dut_small (
        .clk (clk), .reset_n (reset_n), .run (run_s), .step (1'b0),
        .mem_q (16'h8005), .acc (16'h0000), .EXTRA (1'b0),
        .FETCH (FETCH_s), .EXEC1 (EXEC1_s), .EXEC2 (EXEC2_s),
        .IR (IR_s), .operand (operand_s), .EQ (EQ_s), .MI (MI_s),
        .halted (halted_s), .instr_count (instr_count_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic f, input logic e1, input logic e2, input logic h,
                        input logic [15:0] cnt);
        exp_t e;
        e = '{f: f, e1: e1, e2: e2, h: h, cnt: cnt};
        sb.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".fetch"},  {31'd0, FETCH},  {31'd0, e.f});
            chk({tag, ".exec1"},  {31'd0, EXEC1},  {31'd0, e.e1});
            chk({tag, ".exec2"},  {31'd0, EXEC2},  {31'd0, e.e2});
            chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e.h});
            chk({tag, ".count"},  {16'd0, instr_count}, {16'd0, e.cnt});
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] model_s;
        reset_n = 1'b0; run = 1'b0; step = 1'b0; EXTRA = 1'b0;
        mem_q = 16'h0000; acc = 16'h0000; run_s = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        push(0, 0, 0, 0, 16'd0); compare_out("reset");
        chk("reset.ir", {28'd0, IR}, 32'd0);
        chk("reset.operand", {20'd0, operand}, 32'd0);
        repeat (5) begin push(0, 0, 0, 0, 16'd0); tick("idle"); end

        // LDI, single-cycle execute
        run = 1'b1; mem_q = 16'h8005; EXTRA = 1'b0;
        push(1, 0, 0, 0, 16'd0); tick("ldi.f");
        push(0, 1, 0, 0, 16'd0); tick("ldi.e1");
        chk("ldi.ir", {28'd0, IR}, 32'd8);
        chk("ldi.operand", {20'd0, operand}, 32'h005);
        push(1, 0, 0, 0, 16'd1); tick("ldi.ret");

        // ADD with EXEC2
        mem_q = 16'h2010; EXTRA = 1'b1;
        push(0, 1, 0, 0, 16'd1); tick("add.e1");
        chk("add.ir", {28'd0, IR}, 32'd2);
        chk("add.operand", {20'd0, operand}, 32'h010);
        push(0, 0, 1, 0, 16'd1); tick("add.e2");
        push(1, 0, 0, 0, 16'd2); tick("add.ret");
        chk("add.ir_held", {28'd0, IR}, 32'd2);

        // run dropped during FETCH: instruction completes, then IDLE
        run = 1'b0; mem_q = 16'h8005; EXTRA = 1'b0;
        push(0, 1, 0, 0, 16'd2); tick("drop.e1");
        push(0, 0, 0, 0, 16'd3); tick("drop.ret");
        push(0, 0, 0, 0, 16'd3); tick("drop.idle");

        // single step; a second pulse during EXEC1 is not queued
        step = 1'b1;
        push(1, 0, 0, 0, 16'd3); tick("step.f");
        step = 1'b0;
        push(0, 1, 0, 0, 16'd3); tick("step.e1");
        step = 1'b1;
        push(0, 0, 0, 0, 16'd4); tick("step.ret");
        step = 1'b0;
        repeat (2) begin push(0, 0, 0, 0, 16'd4); tick("step.idle"); end

        // run and step together: run wins, sequencer keeps going
        run = 1'b1; step = 1'b1;
        push(1, 0, 0, 0, 16'd4); tick("rs.f");
        step = 1'b0;
        push(0, 1, 0, 0, 16'd4); tick("rs.e1");
        push(1, 0, 0, 0, 16'd5); tick("rs.ret");
        run = 1'b0;
        push(0, 1, 0, 0, 16'd5); tick("rs.e1b");
        push(0, 0, 0, 0, 16'd6); tick("rs.idle");

        // STP halts; EXTRA, run and step are all ignored afterwards
        run = 1'b1; mem_q = 16'h7000; EXTRA = 1'b1;
        push(1, 0, 0, 0, 16'd6); tick("stp.f");
        push(0, 1, 0, 0, 16'd6); tick("stp.e1");
        chk("stp.ir", {28'd0, IR}, 32'd7);
        push(0, 0, 0, 1, 16'd7); tick("stp.halt");
        for (int i = 0; i < 4; i++) begin
            step = i[0]; run = ~i[1];
            push(0, 0, 0, 1, 16'd7); tick("halt.hold");
        end

        // asynchronous reset between edges
        #2 reset_n = 1'b0;
        #1;
        push(0, 0, 0, 0, 16'd0); compare_out("async_rst");
        chk("async_rst.ir", {28'd0, IR}, 32'd0);
        run = 1'b0; step = 1'b0; EXTRA = 1'b0; mem_q = 16'h0000;
        @(posedge clk);
        #1 reset_n = 1'b1;
        push(0, 0, 0, 0, 16'd0); tick("post_rst.idle");

        // condition flags
        acc = 16'h8000; #1;
        chk("flags.8000.mi", {31'd0, MI}, 32'd1);
        chk("flags.8000.eq", {31'd0, EQ}, 32'd0);
        acc = 16'h0000; #1;
        chk("flags.0000.eq", {31'd0, EQ}, 32'd1);
        chk("flags.0000.mi", {31'd0, MI}, 32'd0);
        acc = 16'h7FFF; #1;
        chk("flags.7fff.eq", {31'd0, EQ}, 32'd0);
        chk("flags.7fff.mi", {31'd0, MI}, 32'd0);

        // counter wrap on the narrow instance
        model_s = 4'd0;
        run_s = 1'b1;
        @(posedge clk); #1;
        chk("wrap.first_fetch", {31'd0, FETCH_s}, 32'd1);
        for (int k = 1; k <= 18; k++) begin
            repeat (2) @(posedge clk);
            #1;
            model_s = model_s + 4'd1;
            chk("wrap.count", {28'd0, instr_count_s}, {28'd0, model_s});
            chk("wrap.fetch", {31'd0, FETCH_s}, 32'd1);
        end
        run_s = 1'b0;

        if (sb.size() != 0) chk("sb.leftover", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
